// File: rtl/dff_pipe_pkg.sv
// -----------------------------------------------------------------------------
// dff_pipe_pkg
//   Shared constants and helpers for the dff_pipe delay line.
//   - DFF_PIPE_RESET_VAL : default data value loaded into every stage on reset
//   - occ_w(depth)       : width of the occupancy counter for a given depth
//   - even_par(value)    : even-parity bit of a data word
// -----------------------------------------------------------------------------
package dff_pipe_pkg;

    localparam int unsigned DFF_PIPE_RESET_VAL = 0;

    // Enough bits to count 0..depth inclusive.
    function automatic int unsigned occ_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic even_par(input logic [63:0] value);
        return ^value;
    endfunction

endpackage

// File: rtl/dff_pipe_if.sv
// -----------------------------------------------------------------------------
// dff_pipe_if
//   Bundles the data/control signals of the dff_pipe delay line.
//   Parameters: WIDTH (data bits), DEPTH (stages).
//   Signals:
//     en         shift enable (1 advances, 0 holds everything)
//     flush      clears every valid bit
//     d/d_valid  input beat captured into stage 0
//     q/q_valid  beat in the last stage
//     occupancy  number of stages holding a valid beat
//     parity_err parity mismatch on the last stage (0 unless parity is built)
//   Modports: master drives the inputs, slave is the delay line itself.
// -----------------------------------------------------------------------------
interface dff_pipe_if
    import dff_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);

    logic                       en;
    logic                       flush;
    logic [WIDTH-1:0]           d;
    logic                       d_valid;
    logic [WIDTH-1:0]           q;
    logic                       q_valid;
    logic [occ_w(DEPTH)-1:0]    occupancy;
    logic                       parity_err;

    modport master (
        output en, flush, d, d_valid,
        input  q, q_valid, occupancy, parity_err
    );

    modport slave (
        input  en, flush, d, d_valid,
        output q, q_valid, occupancy, parity_err
    );

endinterface

// File: rtl/dff_stage.sv
// -----------------------------------------------------------------------------
// dff_stage
//   One register stage of the dff_pipe delay line: a data word plus its valid
//   bit, with synchronous active-high reset, shift enable and a valid clear.
//   Ports:
//     clk, rst   clock and synchronous active-high reset
//     en_i       load d_i/vld_i when 1, hold when 0
//     clr_i      clear the valid bit (independent of en_i); data unaffected
//     d_i, vld_i next data word and valid bit from the previous stage
//     q_o, vld_o registered data word and valid bit
// -----------------------------------------------------------------------------
module dff_stage #(
    parameter int           W         = 8,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    input  logic         vld_i,
    output logic [W-1:0] q_o,
    output logic         vld_o
);

    logic [W-1:0] data_q, data_d;
    logic         vld_q,  vld_d;

    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latch.
        data_d = data_q;
        vld_d  = vld_q;
        if (en_i) begin
            data_d = d_i;
            vld_d  = vld_i;
        end
        // Clear wins over shift; data may still move, consumers ignore it.
        if (clr_i) begin
            vld_d = 1'b0;
        end
    end

    // NOTE: data registers are reset too, so q shows RESET_VAL after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: non-blocking assignments for all sequential state.
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule

// File: rtl/dff_pipe.sv
// -----------------------------------------------------------------------------
// dff_pipe
//   Parametrised, stallable delay line of DEPTH enable-gated register stages
//   with per-stage valid tracking, flush and an incrementally kept occupancy
//   count. Latency is DEPTH enabled cycles; all outputs come from registers.
//   Parameters: WIDTH (data bits), DEPTH (stages), RESET_VAL (reset data).
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  dff_pipe_if.slave (en, flush, d, d_valid, q, q_valid,
//          occupancy, parity_err)
//   Configuration:
//     DFF_PIPE_PARITY_EN  when defined, each stage carries an even-parity bit
//                         and parity_err flags a mismatch on a valid last
//                         stage; otherwise parity_err is constant 0.
// -----------------------------------------------------------------------------
module dff_pipe
    import dff_pipe_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter int               DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_PIPE_RESET_VAL)
) (
    input  logic      clk,
    input  logic      rst,
    dff_pipe_if.slave bus
);

    localparam int OCC_W = occ_w(DEPTH);

`ifdef DFF_PIPE_PARITY_EN
    // Parity travels as the MSB of each stage; reset parity is 0.
    localparam int            SW        = WIDTH + 1;
    localparam logic [SW-1:0] STAGE_RST = {1'b0, RESET_VAL};
    logic [SW-1:0] head;
    assign head = {even_par(64'(bus.d)), bus.d};
`else
    localparam int            SW        = WIDTH;
    localparam logic [SW-1:0] STAGE_RST = RESET_VAL;
    logic [SW-1:0] head;
    assign head = bus.d;
`endif

    logic [SW-1:0]    st_in [DEPTH];
    logic [SW-1:0]    st_q  [DEPTH];
    logic [DEPTH-1:0] vld_in;
    logic [DEPTH-1:0] vld_q;

    // ------------------------------------------------------------------
    // Stage chain
    // ------------------------------------------------------------------
    assign st_in[0]  = head;
    assign vld_in[0] = bus.d_valid;

    for (genvar i = 1; i < DEPTH; i++) begin : g_link
        assign st_in[i]  = st_q[i-1];
        assign vld_in[i] = vld_q[i-1];
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        dff_stage #(
            .W         (SW),
            .RESET_VAL (STAGE_RST)
        ) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en_i  (bus.en),
            .clr_i (bus.flush),
            .d_i   (st_in[i]),
            .vld_i (vld_in[i]),
            .q_o   (st_q[i]),
            .vld_o (vld_q[i])
        );
    end

    assign bus.q       = st_q[DEPTH-1][WIDTH-1:0];
    assign bus.q_valid = vld_q[DEPTH-1];

    // ------------------------------------------------------------------
    // Occupancy: updated by +d_valid / -leaving beat rather than a popcount,
    // so the output is a plain register with no adder tree behind it.
    // ------------------------------------------------------------------
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        occ_d = occ_q;
        if (bus.flush) begin
            occ_d = '0;
        end else if (bus.en) begin
            occ_d = occ_q + OCC_W'(bus.d_valid) - OCC_W'(vld_q[DEPTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            occ_q <= '0;
        end else begin
            occ_q <= occ_d;
        end
    end

    assign bus.occupancy = occ_q;

    // ------------------------------------------------------------------
    // Parity check on the last stage
    // ------------------------------------------------------------------
`ifdef DFF_PIPE_PARITY_EN
    // Evaluated on the last stage's next state so the flag lines up with
    // the beat visible on q in the same cycle.
    logic [SW-1:0] last_nxt;
    logic          last_vld_nxt;
    logic          perr_q, perr_d;

    always_comb begin
        last_nxt     = bus.en ? st_in[DEPTH-1] : st_q[DEPTH-1];
        last_vld_nxt = bus.flush ? 1'b0
                     : (bus.en ? vld_in[DEPTH-1] : vld_q[DEPTH-1]);
        perr_d       = last_vld_nxt
                     & (even_par(64'(last_nxt[WIDTH-1:0])) != last_nxt[WIDTH]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perr_q <= 1'b0;
        end else begin
            perr_q <= perr_d;
        end
    end

    assign bus.parity_err = perr_q;
`else
    assign bus.parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dff_pipe.sv
// -----------------------------------------------------------------------------
// tb_dff_pipe
//   Self-checking bench for dff_pipe (WIDTH=8, DEPTH=4). The reference model
//   is a history of the beats accepted on enabled cycles: the output is the
//   beat accepted DEPTH enabled cycles ago, flush invalidates the history and
//   occupancy is the number of still-valid beats in that window.
// -----------------------------------------------------------------------------
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic             valid;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_mis = 0;
    int peak_occ;

    beat_t hist[$];

    dff_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    dff_pipe #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- model
    task automatic model_reset();
        beat_t b;
        hist.delete();
        b.data  = 8'h00;
        b.valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) hist.push_back(b);
    endtask

    task automatic model_edge(input logic r, input logic e, input logic fl,
                              input logic [WIDTH-1:0] dd, input logic dv);
        beat_t b;
        if (r) begin
            model_reset();
        end else begin
            if (fl) begin
                for (int i = 0; i < hist.size(); i++) hist[i].valid = 1'b0;
            end
            if (e) begin
                b.data  = dd;
                b.valid = dv && !fl;
                hist.push_back(b);
                void'(hist.pop_front());
            end
        end
    endtask

    function automatic int model_occ();
        int n = 0;
        for (int i = 0; i < hist.size(); i++) n += int'(hist[i].valid);
        return n;
    endfunction

    task automatic compare();
        check("q_valid", 32'(bus.q_valid), 32'(hist[0].valid));
        check("occupancy", 32'(bus.occupancy), 32'(model_occ()));
        check("parity_err", 32'(bus.parity_err), 32'd0);
        if (hist[0].valid) check("q", 32'(bus.q), 32'(hist[0].data));
        if (int'(bus.occupancy) > peak_occ) peak_occ = int'(bus.occupancy);
    endtask

    // One clock: drive at negedge, model at posedge, compare at next negedge.
    task automatic step(input logic r, input logic e, input logic fl,
                        input logic [WIDTH-1:0] dd, input logic dv);
        rst         = r;
        bus.en      = e;
        bus.flush   = fl;
        bus.d       = dd;
        bus.d_valid = dv;
        @(posedge clk);
        model_edge(r, e, fl, dd, dv);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    // ------------------------------------------------------------ watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        rst = 1'b1; bus.en = 1'b0; bus.flush = 1'b0; bus.d = '0; bus.d_valid = 1'b0;

        // Reset
        do_reset();
        check("rst_q", 32'(bus.q), 32'h00);
        check("rst_q_valid", 32'(bus.q_valid), 32'd0);
        check("rst_occ", 32'(bus.occupancy), 32'd0);
        check("rst_parity_err", 32'(bus.parity_err), 32'd0);

        // Latency: 0xA5 at edge 0 appears after edge 3
        step(1'b0, 1'b1, 1'b0, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            check("lat_not_yet", 32'(bus.q_valid), 32'd0);
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end
        check("lat_q", 32'(bus.q), 32'hA5);
        check("lat_q_valid", 32'(bus.q_valid), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("lat_occ_drain", 32'(bus.occupancy), 32'd0);

        // Stall
        do_reset();
        for (int i = 1; i <= 4; i++) step(1'b0, 1'b1, 1'b0, 8'(i), 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'b0, 8'hEE, 1'b1);
            check("stall_q", 32'(bus.q), 32'h01);
            check("stall_occ", 32'(bus.occupancy), 32'd4);
        end
        for (int i = 2; i <= 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            check("stall_resume_q", 32'(bus.q), 32'(i));
        end

        // Bubbles: 0x11, --, 0x33
        do_reset();
        peak_occ = 0;
        step(1'b0, 1'b1, 1'b0, 8'h11, 1'b1);
        step(1'b0, 1'b1, 1'b0, 8'h22, 1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h33, 1'b1);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        check("bubble_peak_occ", 32'(peak_occ), 32'd2);

        // Flush collision
        do_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0, 8'(8'h50 + i), 1'b1);
        step(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        check("flush_occ", 32'(bus.occupancy), 32'd0);
        check("flush_q_valid", 32'(bus.q_valid), 32'd0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            check("flush_no_77", 32'(bus.q_valid), 32'd0);
        end

        // Flush while stalled
        do_reset();
        step(1'b0, 1'b1, 1'b0, 8'h5A, 1'b1);
        step(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        check("flush_stall_occ", 32'(bus.occupancy), 32'd0);

        // Randomised traffic
        do_reset();
        for (int i = 0; i < 600; i++) begin
            logic r, e, fl, dv;
            r  = ($urandom_range(0, 99) < 2);
            e  = ($urandom_range(0, 99) < 75);
            fl = ($urandom_range(0, 99) < 5);
            dv = ($urandom_range(0, 99) < 60);
            step(r, e, fl, 8'($urandom), dv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
